scoreboard_issue: RTL and testbench
===================================

Name: scoreboard_issue

Overview:
- Issue-side counterpart to the pipeline's combinational hazard check.
- Sits between IF and ID, holding one registered instruction slot.
- Keeps a per-register scoreboard of in-flight writers: an instruction's destination is marked at issue and released when write-back retires it.
- Issue is blocked while any source register read by the IF instruction is still pending; the block drives the valid/ready handshake into ID.

Parameters:
- REG_ADDR_W, 4, register index width; NREGS = 2**REG_ADDR_W.
- CNT_W, 2, width of each per-register pending-writer counter; saturates at 2**CNT_W-1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  IF holds an instruction.
- in_stage  in  t_stage  IF instruction (operation, r1, r2, rw).
- in_ready  out  1  instruction accepted this cycle.
- out_valid  out  1  issue slot holds an instruction for ID.
- out_stage  out  t_stage  registered instruction to ID.
- out_ready  in  1  ID consumes the slot.
- wb_valid  in  1  write-back retires a register write.
- wb_rw  in  REG_ADDR_W  retired destination register.
- flush  in  1  kill the slot and clear the scoreboard.
- stall  out  1  in_valid && !in_ready (combinational).
- wb_err  out  1  sticky: write-back to a register with zero pending.

Behaviour:
- Reset (rst_n=0 at posedge): out_valid=0, out_stage=0, all counters=0, wb_err=0.
- Operation classes:
  - reads = ADD, SUB, AND, WRL, RDL.
  - writes = ALO, AHI, ADD, SUB, AND, RDL.
- Effective pending of register r: pend(r) = cnt[r] - (wb_valid && wb_rw==r && cnt[r]!=0). A same-cycle write-back therefore releases the reader, because the register file is written this edge and read in ID next cycle.
- hazard = reads(in_stage) && (pend(r1)!=0 || pend(r2)!=0).
- Write-saturation block:
  - wsat = writes(in_stage) && pend(rw)==max.
  - A blocked write waits; it is never dropped.
- in_ready = !flush && (!out_valid || out_ready) && !hazard && !wsat.
- Issue (in_valid && in_ready):
  - out_stage <= in_stage; out_valid <= 1 at the next edge. Latency is 1 cycle.
  - If writes(in_stage), cnt[rw] increments at that edge.
- If out_valid && out_ready with no issue, out_valid <= 0.
- Counter update per edge: cnt[r] += (issue && writes && rw==r) - (wb hit on r). Issue and write-back to the same r in one cycle leave cnt unchanged.
- Write-back with cnt[wb_rw]==0: counter stays 0 and wb_err <= 1. wb_err is cleared only by reset.
- flush=1:
  - At the edge: out_valid <= 0, all counters <= 0; any write-back that cycle is ignored and does not set wb_err.
  - in_ready=0 during the flush cycle.
  - Upstream guarantees that flush also kills ID/EX/MEM.
- Flush asserted together with reset: reset wins; the result is identical.
- Reset mid-stall: the scoreboard clears, so a stalled instruction may issue in the first cycle after reset.
- No operation classes: neither reads nor writes apply, so the instruction issues whenever the slot is free.

Optional Feature:
- Macro SCOREBOARD_ISSUE_STATS_EN.
- Defined: adds output port stall_cycles (32 bits, wrapping).
  - Increments each cycle stall=1 and flush=0.
  - Reset to 0 by rst_n.
- Undefined: no port and no counter logic; all other behaviour is identical.

Decomposition:
- Shared package / common.vh holds:
  - t_stage and the operation enum (existing).
  - New functions op_reads(op) and op_writes(op), so the hazard check and this block share one classification.
  - REG_ADDR_W default constant.
- One sub-module, scoreboard_cnt: the NREGS counter array.
  - Inputs: inc_en, inc_idx, dec_en, dec_idx, clr.
  - Outputs: pend vector, err pulse.
- The top level holds the issue slot, handshake and stats.

Test Plan:
- Reset, then in_valid with ADD r1=2 r2=3 rw=5, out_ready=1 -> in_ready=1; out_valid=1 next cycle with that stage; cnt[5]=1.
- Then SUB r1=5 r2=0 rw=6 -> stall=1 each cycle until wb_valid with wb_rw=5; issued in that same cycle; cnt[5]=0, cnt[6]=1.
- Four ALO writes to rw=7 with no write-back (CNT_W=2) -> three issue; the fourth stalls until one wb_rw=7.
- out_ready=0 with slot full -> in_ready=0, out_stage held stable; release -> next instruction issues on the same edge the slot drains.
- flush while cnt[4]=2 and a stalled reader of r4 is present -> next cycle out_valid=0, all counters 0; the reader issues in the following cycle.
- wb_valid with wb_rw=9 while cnt[9]=0 -> wb_err=1 and stays high; counter remains 0. Under SCOREBOARD_ISSUE_STATS_EN, 3 stall cycles -> stall_cycles=3.

Source files
------------

// File: rtl/scoreboard_issue_pkg.sv
// Shared types and operation classification for the issue scoreboard and the hazard check.
package scoreboard_issue_pkg;

   localparam int SB_REG_ADDR_W = 4;

   typedef enum logic [2:0] {
      OP_NOP, OP_ALO, OP_AHI, OP_ADD, OP_SUB, OP_AND, OP_WRL, OP_RDL
   } t_op;

   typedef struct packed {
      t_op                      op;
      logic [SB_REG_ADDR_W-1:0] r1;
      logic [SB_REG_ADDR_W-1:0] r2;
      logic [SB_REG_ADDR_W-1:0] rw;
   } t_stage;

   function automatic logic op_reads(input t_op op);
      return (op inside {OP_ADD, OP_SUB, OP_AND, OP_WRL, OP_RDL});
   endfunction

   function automatic logic op_writes(input t_op op);
      return (op inside {OP_ALO, OP_AHI, OP_ADD, OP_SUB, OP_AND, OP_RDL});
   endfunction

endpackage

// File: rtl/scoreboard_issue_cnt.sv
// Per-register pending-writer counters; pend reflects a same-cycle write-back already applied.
module scoreboard_cnt
   import scoreboard_issue_pkg::*;
#(
   parameter int REG_ADDR_W = SB_REG_ADDR_W,
   parameter int CNT_W      = 2,
   localparam int NREGS     = 2**REG_ADDR_W
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            inc_en,
   input  logic [REG_ADDR_W-1:0]           inc_idx,
   input  logic                            dec_en,
   input  logic [REG_ADDR_W-1:0]           dec_idx,
   input  logic                            clr,
   output logic [NREGS-1:0][CNT_W-1:0]     pend,
   output logic                            err
);

   logic [NREGS-1:0][CNT_W-1:0] cnt;

   for (genvar r = 0; r < NREGS; r++) begin : g_reg
      logic             inc, dec;
      logic [CNT_W-1:0] q;

      assign inc      = inc_en && (inc_idx == REG_ADDR_W'(r));
      assign dec      = dec_en && (dec_idx == REG_ADDR_W'(r)) && (q != '0);
      assign cnt[r]   = q;
      assign pend[r]  = q - CNT_W'(dec);

      // Saturation is prevented upstream: inc is only granted when pend is below max.
      always_ff @(posedge clk) begin
         if (!rst_n || clr) q <= '0;
         else               q <= q + CNT_W'(inc) - CNT_W'(dec);
      end
   end

   assign err = dec_en && !clr && (cnt[dec_idx] == '0);

endmodule

// File: rtl/scoreboard_issue.sv
// Issue slot between IF and ID, blocking readers of registers with in-flight writers.
// Optional stall counter port stall_cycles under SCOREBOARD_ISSUE_STATS_EN.
module scoreboard_issue
   import scoreboard_issue_pkg::*;
#(
   parameter int REG_ADDR_W = SB_REG_ADDR_W,
   parameter int CNT_W      = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  t_stage                in_stage,
   output logic                  in_ready,
   output logic                  out_valid,
   output t_stage                out_stage,
   input  logic                  out_ready,
   input  logic                  wb_valid,
   input  logic [REG_ADDR_W-1:0] wb_rw,
   input  logic                  flush,
   output logic                  stall,
   output logic                  wb_err
`ifdef SCOREBOARD_ISSUE_STATS_EN
   ,
   output logic [31:0]           stall_cycles
`endif
);

   localparam int               NREGS   = 2**REG_ADDR_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [NREGS-1:0][CNT_W-1:0] pend;
   logic                        hazard, wsat, issue, cnt_err;

   assign hazard   = op_reads(in_stage.op) &&
                     ((pend[in_stage.r1] != '0) || (pend[in_stage.r2] != '0));
   assign wsat     = op_writes(in_stage.op) && (pend[in_stage.rw] == CNT_MAX);
   assign in_ready = !flush && (!out_valid || out_ready) && !hazard && !wsat;
   assign issue    = in_valid && in_ready;
   assign stall    = in_valid && !in_ready;

   scoreboard_cnt #(.REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_en  (issue && op_writes(in_stage.op)),
      .inc_idx (in_stage.rw),
      .dec_en  (wb_valid),
      .dec_idx (wb_rw),
      .clr     (flush),
      .pend    (pend),
      .err     (cnt_err)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_stage <= '0;
         wb_err    <= 1'b0;
      end else begin
         if (flush)          out_valid <= 1'b0;
         else if (issue) begin
            out_valid <= 1'b1;
            out_stage <= in_stage;
         end else if (out_ready) out_valid <= 1'b0;
         if (cnt_err) wb_err <= 1'b1;
      end
   end

`ifdef SCOREBOARD_ISSUE_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n)              stall_cycles <= '0;
      else if (stall && !flush) stall_cycles <= stall_cycles + 32'd1;
   end
`endif

endmodule

// File: tb/tb_scoreboard_issue.sv
// Bench for scoreboard_issue: reference model predicts handshake, expected stages queue up at issue.
module tb_scoreboard_issue;
   import scoreboard_issue_pkg::*;

   localparam int CNT_MAX = 3;

   logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic       wb_valid = 1'b0, flush = 1'b0;
   logic [3:0] wb_rw = '0;
   t_stage     in_stage = '0;
   logic       in_ready, out_valid, stall, wb_err;
   t_stage     out_stage;
`ifdef SCOREBOARD_ISSUE_STATS_EN
   logic [31:0] stall_cycles;
`endif

   always #5 clk = ~clk;

   scoreboard_issue dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_stage(in_stage),
      .in_ready(in_ready), .out_valid(out_valid), .out_stage(out_stage),
      .out_ready(out_ready), .wb_valid(wb_valid), .wb_rw(wb_rw), .flush(flush),
      .stall(stall), .wb_err(wb_err)
`ifdef SCOREBOARD_ISSUE_STATS_EN
      , .stall_cycles(stall_cycles)
`endif
   );

   int          m_cnt [16];
   bit          m_ov, m_err;
   int unsigned m_stalls;
   t_stage      exp_q [$];
   int          n_chk = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit is_rd(input t_op op);
      return op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_WRL || op == OP_RDL;
   endfunction

   function automatic bit is_wr(input t_op op);
      return op == OP_ALO || op == OP_AHI || op == OP_ADD || op == OP_SUB ||
             op == OP_AND || op == OP_RDL;
   endfunction

   function automatic int m_pend(input logic [3:0] r);
      return m_cnt[r] - ((wb_valid && wb_rw == r && m_cnt[r] > 0) ? 1 : 0);
   endfunction

   task automatic model_clear(input bit full);
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_ov = 1'b0;
      exp_q.delete();
      if (full) begin
         m_err    = 1'b0;
         m_stalls = 0;
      end
   endtask

   task automatic step();
      bit rdy, iss;
      rdy = !flush && (!m_ov || out_ready) &&
            !(is_rd(in_stage.op) && (m_pend(in_stage.r1) != 0 || m_pend(in_stage.r2) != 0)) &&
            !(is_wr(in_stage.op) && m_pend(in_stage.rw) == CNT_MAX);
      iss = in_valid && rdy;
      #1;
      if (rst_n) begin
         chk("in_ready", in_ready, rdy);
         chk("stall", stall, in_valid && !rdy);
         chk("out_valid", out_valid, m_ov);
         if (m_ov && exp_q.size() > 0) chk("out_stage", out_stage, exp_q[0]);
         chk("wb_err", wb_err, m_err);
`ifdef SCOREBOARD_ISSUE_STATS_EN
         chk("stall_cycles", stall_cycles, m_stalls);
`endif
      end
      @(posedge clk);
      if (!rst_n) model_clear(1'b1);
      else if (flush) model_clear(1'b0);
      else begin
         if (in_valid && !rdy) m_stalls++;
         if (wb_valid) begin
            if (m_cnt[wb_rw] > 0) m_cnt[wb_rw]--;
            else m_err = 1'b1;
         end
         if (iss && is_wr(in_stage.op)) m_cnt[in_stage.rw]++;
         if (iss) begin
            if (m_ov) void'(exp_q.pop_front());
            exp_q.push_back(in_stage);
            m_ov = 1'b1;
         end else if (m_ov && out_ready) begin
            void'(exp_q.pop_front());
            m_ov = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   task automatic drv(input bit v, input t_op op, input int r1, input int r2, input int rw,
                      input bit ordy, input bit wbv = 1'b0, input int wbr = 0,
                      input bit fl = 1'b0);
      in_valid       = v;
      in_stage.op    = op;
      in_stage.r1    = 4'(r1);
      in_stage.r2    = 4'(r2);
      in_stage.rw    = 4'(rw);
      out_ready      = ordy;
      wb_valid       = wbv;
      wb_rw          = 4'(wbr);
      flush          = fl;
   endtask

   initial begin
      model_clear(1'b1);
      rst_n = 1'b0;
      step(); step();
      rst_n = 1'b1;
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_stage", out_stage, '0);
      chk("rst_wb_err", wb_err, 1'b0);

      // basic issue, then RAW stall released by same-cycle write-back
      drv(1, OP_ADD, 2, 3, 5, 1); step();
      drv(1, OP_SUB, 5, 0, 6, 1); repeat (3) step();
      drv(1, OP_SUB, 5, 0, 6, 1, 1, 5); step();
      drv(0, OP_NOP, 0, 0, 0, 1); step();

      // write saturation on r7
      drv(1, OP_ALO, 0, 0, 7, 1); repeat (5) step();
      drv(1, OP_ALO, 0, 0, 7, 1, 1, 7); step();

      // backpressure: slot full and held, then drains and refills on one edge
      drv(1, OP_ALO, 0, 0, 8, 0); repeat (3) step();
      drv(1, OP_ALO, 0, 0, 8, 1); step();
      drv(0, OP_NOP, 0, 0, 0, 1); step();

      // flush with stalled reader of r4, write-back in the flush cycle ignored
      drv(1, OP_ALO, 0, 0, 4, 1); repeat (2) step();
      drv(1, OP_RDL, 4, 4, 1, 1); repeat (2) step();
      drv(1, OP_RDL, 4, 4, 1, 1, 1, 9, 1); step();
      drv(1, OP_RDL, 4, 4, 1, 1); step();
      drv(0, OP_NOP, 0, 0, 0, 1); step();

      // write-back to idle register sets sticky error
      drv(0, OP_NOP, 0, 0, 0, 1, 1, 9); step();
      drv(0, OP_NOP, 0, 0, 0, 1); repeat (2) step();

      // classless op issues regardless of r7 pending; WRL reader stalls
      drv(1, OP_NOP, 7, 7, 7, 1); step();
      drv(1, OP_WRL, 7, 0, 0, 1); repeat (2) step();
      rst_n = 1'b0; step(); rst_n = 1'b1; step();

      // flush together with reset
      drv(1, OP_ALO, 0, 0, 3, 1); step();
      drv(1, OP_ADD, 3, 3, 2, 1); step();
      rst_n = 1'b0; flush = 1'b1; step();
      rst_n = 1'b1; flush = 1'b0; step();
      drv(0, OP_NOP, 0, 0, 0, 1); step();

      // random traffic on a small register window
      for (int i = 0; i < 400; i++) begin
         drv($urandom_range(0, 3) != 0, t_op'($urandom_range(0, 7)),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 3), $urandom_range(0, 29) == 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
